// File: rtl/register_16bit_pkg.sv
// Shared defaults for the 16-bit byte-lane holding register.
package register_16bit_pkg;

    localparam int          HALF_WIDTH_DEF  = 8;
    localparam logic [15:0] RESET_VALUE_DEF = 16'h0000;

    // Assemble a full word from its high and low byte lanes.
    function automatic logic [15:0] join_lanes(input logic [7:0] high, input logic [7:0] low);
        return {high, low};
    endfunction

endpackage

// File: rtl/register_16bit_byte_lane_reg.sv
// One byte lane: a load-enabled register with asynchronous active-high reset.
module byte_lane_reg #(
    parameter int                  WIDTH     = 8,
    parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Lane storage: reset wins, otherwise capture on load, otherwise hold.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_data;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_16bit.sv
// 16-bit holding register assembled one byte lane at a time from an 8-bit bus.
module register_16bit
    import register_16bit_pkg::*;
#(
    parameter int                          HALF_WIDTH  = HALF_WIDTH_DEF,
    parameter logic [2*HALF_WIDTH-1:0]     RESET_VALUE = RESET_VALUE_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    loadhigh,
    input  logic                    loadlow,
    input  logic [HALF_WIDTH-1:0]   halfvaluein,
    output logic [2*HALF_WIDTH-1:0] valueout
);

    logic [HALF_WIDTH-1:0] w_high;
    logic [HALF_WIDTH-1:0] w_low;

    byte_lane_reg #(
        .WIDTH     (HALF_WIDTH),
        .RESET_VAL (RESET_VALUE[2*HALF_WIDTH-1:HALF_WIDTH])
    ) u_high_lane (
        .i_clock (clock),
        .i_reset (reset),
        .i_load  (loadhigh),
        .i_data  (halfvaluein),
        .o_q     (w_high)
    );

    byte_lane_reg #(
        .WIDTH     (HALF_WIDTH),
        .RESET_VAL (RESET_VALUE[HALF_WIDTH-1:0])
    ) u_low_lane (
        .i_clock (clock),
        .i_reset (reset),
        .i_load  (loadlow),
        .i_data  (halfvaluein),
        .o_q     (w_low)
    );

    // Output comes straight from the lane flops; no logic after them.
    assign valueout = {w_high, w_low};

endmodule

// File: tb/tb_register_16bit.sv
// Self-checking bench for register_16bit: directed scenarios then randomized loads.
module tb_register_16bit;

    logic        clock;
    logic        reset;
    logic        loadhigh;
    logic        loadlow;
    logic [7:0]  halfvaluein;
    logic [15:0] valueout;

    int total;
    int bad;

    int unsigned model_hi;
    int unsigned model_lo;

    register_16bit dut (
        .clock       (clock),
        .reset       (reset),
        .loadhigh    (loadhigh),
        .loadlow     (loadlow),
        .halfvaluein (halfvaluein),
        .valueout    (valueout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] expected);
        total++;
        assert (valueout === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, valueout, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] model_word();
        int unsigned w;
        w = model_hi * 256 + model_lo;
        return w[15:0];
    endfunction

    initial begin
        logic [15:0] held;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        loadhigh = 1'b0;
        loadlow = 1'b0;
        halfvaluein = 8'h00;
        #2;
        check("reset_state", 16'h0000);
        step();
        reset = 1'b0;

        // Preload 0x1234 one lane at a time
        halfvaluein = 8'h12; loadhigh = 1'b1;
        step();
        check("preload_hi", 16'h1200);
        loadhigh = 1'b0; halfvaluein = 8'h34; loadlow = 1'b1;
        step();
        check("preload_lo", 16'h1234);
        loadlow = 1'b0;

        // Asynchronous reset between edges
        halfvaluein = 8'hFF;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 16'h0000);
        step();
        reset = 1'b0;
        step();
        check("reset_release", 16'h0000);

        halfvaluein = 8'hFF; loadhigh = 1'b1;
        step();
        check("high_load", 16'hFF00);
        loadhigh = 1'b0; halfvaluein = 8'hEE;
        step();
        check("high_hold", 16'hFF00);

        loadlow = 1'b1;
        step();
        check("low_load", 16'hFFEE);
        loadlow = 1'b0;
        step();
        check("low_hold", 16'hFFEE);

        loadhigh = 1'b1; loadlow = 1'b1; halfvaluein = 8'hEE;
        step();
        check("both_ee", 16'hEEEE);
        halfvaluein = 8'h5A;
        step();
        check("both_5a", 16'h5A5A);

        // Reset asserted across an edge with both strobes active
        halfvaluein = 8'hC3;
        reset = 1'b1;
        step();
        check("reset_priority", 16'h0000);
        reset = 1'b0; loadhigh = 1'b0;
        step();
        check("post_reset_low", 16'h00C3);
        loadlow = 1'b0;

        for (int i = 0; i < 8; i++) begin
            halfvaluein = ~halfvaluein;
            step();
            check("hold_toggle", 16'h00C3);
        end

        // Randomized phase against an arithmetic lane model
        model_hi = 0;
        model_lo = 195;
        for (int i = 0; i < 300; i++) begin
            loadhigh    = 1'($urandom_range(0, 1));
            loadlow     = 1'($urandom_range(0, 1));
            halfvaluein = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) begin
                held = model_word();
                #2;
                reset = 1'b1;
                #1;
                model_hi = 0;
                model_lo = 0;
                check("rand_async_reset", model_word());
                step();
                reset = 1'b0;
                check("rand_reset_hold", model_word());
            end else begin
                step();
                if (loadhigh) model_hi = halfvaluein;
                if (loadlow)  model_lo = halfvaluein;
                check("rand_load", model_word());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
